// File: rtl/stacker_pkg.sv
// Shared definitions for the button conditioning logic.
//   state_t      : one-hot 8-bit debouncer state, also driven out for debug/LEDs
//   *_DEF        : default cycle counts for a 100 MHz system clock
//   max3()       : helper used to size the shared cycle counter
package stacker_pkg;

  typedef enum logic [7:0] {
    INI  = 8'b0000_0001,
    WQ   = 8'b0000_0010,
    SCEN = 8'b0000_0100,
    HOLD = 8'b0000_1000,
    MCEN = 8'b0001_0000,
    RPT  = 8'b0010_0000,
    WFQ  = 8'b0100_0000,
    REL  = 8'b1000_0000
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 2_500_000;   // 25 ms
  localparam int HOLD_CYCLES_DEF     = 50_000_000;  // 500 ms
  localparam int REPEAT_CYCLES_DEF   = 10_000_000;  // 100 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_debouncer_if.sv
// Button pad in, conditioned button events out.
//   btn_in   : raw asynchronous pad level
//   db_level : debounced level
//   scen     : one-cycle strobe per accepted press
//   mcen     : one-cycle strobe on press, then auto-repeat while held
//   rel      : one-cycle strobe per accepted release
//   state_o  : one-hot debouncer state
// Signalling: there is no valid/ready handshake. Every strobe is a
// single-cycle, clk-synchronous pulse that the consumer must take in the
// cycle it is high; the producer never waits for the consumer.
interface btn_debouncer_if;
  logic       btn_in;
  logic       db_level;
  logic       scen;
  logic       mcen;
  logic       rel;
  logic [7:0] state_o;

  // Debouncer side
  modport master (
    input  btn_in,
    output db_level, scen, mcen, rel, state_o
  );

  // Consumer / pad side
  modport slave (
    output btn_in,
    input  db_level, scen, mcen, rel, state_o
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input.
//   clk : destination clock
//   rst : asynchronous active-low reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronised output, two clk edges behind d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/btn_debouncer.sv
// Push-button conditioner: synchronises the pad, filters bounce and produces
// press (scen), auto-repeat (mcen) and release (rel) strobes plus a
// debounced level. All outputs are decoded from the one-hot state register.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : btn_debouncer_if.master (btn_in in; db_level/scen/mcen/rel/state_o out)
module btn_debouncer
  import stacker_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  btn_debouncer_if.master    bus
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

  // Terminal counts. The repeat terminal is one short because the MCEN
  // cycle itself is part of the repeat period.
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 2);

  logic          btn_sync;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    st;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (btn_sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INI;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INI: begin
        if (btn_sync) begin
          state_d = WQ;
          cnt_d   = '0;
        end
      end
      WQ: begin
        if (!btn_sync) begin
          state_d = INI;
        end else if (cnt_q == DB_LAST) begin
          state_d = SCEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCEN: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: begin
        if (!btn_sync) begin
          state_d = WFQ;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = MCEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MCEN: begin
        state_d = RPT;
        cnt_d   = '0;
      end
      RPT: begin
        if (!btn_sync) begin
          state_d = WFQ;
          cnt_d   = '0;
        end else if (cnt_q == RPT_LAST) begin
          state_d = MCEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WFQ: begin
        // Any high sample restarts the quiet window (release bounce).
        if (btn_sync) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      REL: begin
        state_d = INI;
        cnt_d   = '0;
      end
      default: begin
        state_d = INI;
        cnt_d   = '0;
      end
    endcase
  end

  // Each output is a single state bit or an OR of state bits, so nothing
  // combinational from btn_in reaches the pins.
  assign st           = state_q;
  assign bus.state_o  = st;
  assign bus.scen     = st[2];
  assign bus.mcen     = st[2] | st[4];
  assign bus.rel      = st[7];
  assign bus.db_level = |st[6:2];

endmodule

// File: tb/tb_btn_debouncer.sv
module tb_btn_debouncer;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic btn_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  btn_debouncer_if bus ();
  assign bus.btn_in = btn_in;

  btn_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  // ---------------- counters / checker ----------------
  int total;
  int bad;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase-level view of the button: idle (counting consecutive high samples),
  // the press cycle, held (age counted from the press cycle, repeat strobes by
  // arithmetic on age), releasing (counting consecutive low samples), and the
  // release cycle.
  typedef enum int {P_IDLE, P_PRESS, P_HELD, P_RELEASING, P_REL} phase_t;
  phase_t m_phase;
  int     m_run;
  int     m_age;
  logic   m_s1;
  logic   m_sync;

  // expected vector: {state[7:0], db_level, scen, mcen, rel}
  logic [11:0] exp_q[$];

  task automatic model_reset();
    m_phase = P_IDLE;
    m_run   = 0;
    m_age   = 0;
    m_s1    = 1'b0;
    m_sync  = 1'b0;
  endtask

  function automatic logic [11:0] model_outputs();
    logic [7:0] s;
    logic db, sc, mc, rl;
    s = 8'h01; db = 0; sc = 0; mc = 0; rl = 0;
    case (m_phase)
      P_IDLE:  s = (m_run == 0) ? 8'h01 : 8'h02;
      P_PRESS: begin s = 8'h04; db = 1; sc = 1; mc = 1; end
      P_HELD: begin
        db = 1;
        if (m_age < H + 1)                 s = 8'h08;
        else if ((m_age - H - 1) % R == 0) begin s = 8'h10; mc = 1; end
        else                               s = 8'h20;
      end
      P_RELEASING: begin s = 8'h40; db = 1; end
      P_REL:       begin s = 8'h80; rl = 1; end
      default: ;
    endcase
    return {s, db, sc, mc, rl};
  endfunction

  // Advance the model across one rising edge.
  task automatic model_step();
    logic v;
    bit   checked;
    if (!rst_n) begin
      model_reset();
      return;
    end
    v      = m_sync;      // synchronised level seen at this edge
    m_sync = m_s1;
    m_s1   = btn_in;
    case (m_phase)
      P_IDLE: begin
        m_run = v ? m_run + 1 : 0;
        if (m_run == D + 1) m_phase = P_PRESS;
      end
      P_PRESS: begin
        m_phase = P_HELD;
        m_age   = 1;
      end
      P_HELD: begin
        m_age++;
        // The edge that closes a repeat strobe cycle ignores the button.
        checked = !(m_age >= H + 2 && (m_age - H - 2) % R == 0);
        if (checked && !v) begin
          m_phase = P_RELEASING;
          m_run   = 0;
        end
      end
      P_RELEASING: begin
        if (v) m_run = 0;
        else begin
          m_run++;
          if (m_run == D) m_phase = P_REL;
        end
      end
      P_REL: begin
        m_phase = P_IDLE;
        m_run   = 0;
      end
      default: ;
    endcase
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic compare_outputs();
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 8'd0, 8'd1);
      return;
    end
    e = exp_q.pop_front();
    check("state_o",  bus.state_o,        e[11:4]);
    check("db_level", {7'd0, bus.db_level}, {7'd0, e[3]});
    check("scen",     {7'd0, bus.scen},     {7'd0, e[2]});
    check("mcen",     {7'd0, bus.mcen},     {7'd0, e[1]});
    check("rel",      {7'd0, bus.rel},      {7'd0, e[0]});
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: set the pad, cross one rising edge, compare
  // at the next falling edge.
  task automatic drive(input logic b);
    btn_in = b;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outputs());
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic drive_n(input logic b, input int n);
    for (int i = 0; i < n; i++) drive(b);
  endtask

  // Asynchronous reset asserted away from the clock edge; outputs must drop
  // without waiting for a clock.
  task automatic async_reset_pulse(input int cycles);
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.delete();
    exp_q.push_back(model_outputs());
    compare_outputs();
    drive_n(btn_in, cycles);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    btn_in = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst_state",    bus.state_o, 8'h01);
    check("rst_outs",     {4'd0, bus.db_level, bus.scen, bus.mcen, bus.rel}, 8'h00);
    rst_n = 1'b1;

    // idle
    drive_n(1'b0, 20);

    // clean press, then release
    drive_n(1'b1, 12);
    drive_n(1'b0, 12);

    // bouncy press: 2-cycle toggles, then steady high
    for (int i = 0; i < 10; i++) drive(((i / 2) % 2) == 0);
    drive_n(1'b1, 12);
    drive_n(1'b0, 12);

    // long hold with auto-repeat, then release with a 1-cycle glitch
    drive_n(1'b1, 40);
    drive_n(1'b0, 3);
    drive(1'b1);
    drive_n(1'b0, 15);

    // reset during HOLD with the button still held
    drive_n(1'b1, 10);
    async_reset_pulse(2);
    drive_n(1'b1, 15);
    drive_n(1'b0, 15);

    // random runs of levels
    repeat (60) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      drive_n(lvl, len);
    end

    // random single-cycle bounce bursts
    repeat (200) drive(1'($urandom_range(0, 1)));

    // random reset in the middle of random activity
    drive_n(1'b1, $urandom_range(5, 25));
    async_reset_pulse($urandom_range(1, 3));
    drive_n(1'b1, 20);
    drive_n(1'b0, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
